// File: rtl/memory_bus_if.sv
// ============================================================================
//  Module      : memory_bus_if
//  Description : CPU-side request/response signals of the memory bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface memory_bus_if;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_in;
    logic        bus_write_enable;
    logic        bus_request;
    logic        bus_busy;
    logic        bus_done;
    logic [7:0]  bus_data_out;

    modport master (
        output bus_address, bus_data_in, bus_write_enable, bus_request,
        input  bus_busy, bus_done, bus_data_out
    );

    modport slave (
        input  bus_address, bus_data_in, bus_write_enable, bus_request,
        output bus_busy, bus_done, bus_data_out
    );
endinterface

`default_nettype wire

// File: rtl/memory_bus.sv
// ============================================================================
//  Module      : memory_bus
//  Description : Decodes CPU accesses to RAM/ROM/peripherals/unmapped and
//                returns each one with a fixed-latency done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_bus #(
    parameter int         ROM_ADDR_WIDTH = 12,
    parameter logic [7:0] PERIPH_PAGE    = 8'h40,
    parameter logic [7:0] UNMAPPED_VALUE = 8'hFF
) (
    input  wire logic                      clk,
    input  wire logic                      reset_n,
    memory_bus_if.slave                    bus,
    output logic [9:0]                     ram_address,
    output logic [7:0]                     ram_data_in,
    output logic                           ram_write_enable,
    input  wire logic [7:0]                ram_data_out,
    output logic [ROM_ADDR_WIDTH-1:0]      rom_address,
    input  wire logic [7:0]                rom_data_out,
    input  wire logic [3:0]                buttons,
    output logic [7:0]                     leds
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;
    typedef enum logic [1:0] {RG_RAM, RG_ROM, RG_PERIPH, RG_NONE} region_t;

    localparam logic [7:0] c_OFF_BUTTONS = 8'h00;
    localparam logic [7:0] c_OFF_TICK_LO = 8'h04;
    localparam logic [7:0] c_OFF_TICK_HI = 8'h05;
    localparam logic [7:0] c_OFF_LEDS    = 8'h08;

    state_t      r_state;
    region_t     r_region;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [7:0]  r_offset;
    logic [7:0]  r_periph_rd;
    logic [15:0] r_tick;
    logic [7:0]  r_tick_shadow;
    logic [3:0]  r_btn_meta;
    logic [3:0]  r_btn_sync;

    region_t     w_region;
    logic [7:0]  w_periph_rd;
    logic        w_tick_clear;
    logic        w_tick_latch;

    always_comb begin
        w_region = RG_NONE;
        if (bus.bus_address[15:10] == 6'd0)
            w_region = RG_RAM;
        else if (bus.bus_address[15:8] == PERIPH_PAGE)
            w_region = RG_PERIPH;
        else if (&bus.bus_address[15:ROM_ADDR_WIDTH])
            w_region = RG_ROM;
    end

    always_comb begin
        case (r_offset)
            c_OFF_BUTTONS: w_periph_rd = {4'b0000, r_btn_sync};
            c_OFF_TICK_LO: w_periph_rd = r_tick[7:0];
            c_OFF_TICK_HI: w_periph_rd = r_tick_shadow;
            c_OFF_LEDS:    w_periph_rd = leds;
            default:       w_periph_rd = UNMAPPED_VALUE;
        endcase
    end

    // Tick side effects happen only in the ACCESS cycle of a peripheral access
    assign w_tick_clear = (r_state == S_ACCESS) && (r_region == RG_PERIPH) &&
                          r_we && (r_offset == c_OFF_TICK_LO);
    assign w_tick_latch = (r_state == S_ACCESS) && (r_region == RG_PERIPH) &&
                          !r_we && (r_offset == c_OFF_TICK_LO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_region         <= RG_NONE;
            r_we             <= 1'b0;
            r_wdata          <= 8'd0;
            r_offset         <= 8'd0;
            r_periph_rd      <= 8'd0;
            r_tick           <= 16'd0;
            r_tick_shadow    <= 8'd0;
            r_btn_meta       <= 4'd0;
            r_btn_sync       <= 4'd0;
            bus.bus_busy     <= 1'b0;
            bus.bus_done     <= 1'b0;
            bus.bus_data_out <= 8'd0;
            ram_address      <= 10'd0;
            ram_data_in      <= 8'd0;
            ram_write_enable <= 1'b0;
            rom_address      <= '0;
            leds             <= 8'd0;
        end else begin
            r_btn_meta       <= buttons;
            r_btn_sync       <= r_btn_meta;
            r_tick           <= w_tick_clear ? 16'd0 : r_tick + 16'd1;
            bus.bus_done     <= 1'b0;
            ram_write_enable <= 1'b0;
            if (w_tick_latch)
                r_tick_shadow <= r_tick[15:8];

            case (r_state)
                S_IDLE: begin
                    if (bus.bus_request) begin
                        r_region     <= w_region;
                        r_we         <= bus.bus_write_enable;
                        r_wdata      <= bus.bus_data_in;
                        r_offset     <= bus.bus_address[7:0];
                        bus.bus_busy <= 1'b1;
                        r_state      <= S_ACCESS;
                        // Only the addressed memory sees a new address; the other holds
                        if (w_region == RG_RAM) begin
                            ram_address      <= bus.bus_address[9:0];
                            ram_data_in      <= bus.bus_data_in;
                            ram_write_enable <= bus.bus_write_enable;
                        end
                        if (w_region == RG_ROM)
                            rom_address <= bus.bus_address[ROM_ADDR_WIDTH-1:0];
                    end
                end
                S_ACCESS: begin
                    if (r_region == RG_PERIPH) begin
                        if (r_we) begin
                            if (r_offset == c_OFF_LEDS)
                                leds <= r_wdata;
                        end else begin
                            r_periph_rd <= w_periph_rd;
                        end
                    end
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!r_we) begin
                        case (r_region)
                            RG_RAM:    bus.bus_data_out <= ram_data_out;
                            RG_ROM:    bus.bus_data_out <= rom_data_out;
                            RG_PERIPH: bus.bus_data_out <= r_periph_rd;
                            default:   bus.bus_data_out <= UNMAPPED_VALUE;
                        endcase
                    end
                    bus.bus_done <= 1'b1;
                    r_state      <= S_DONE;
                end
                default: begin
                    bus.bus_busy <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
